// File: rtl/image_scan_grey.sv
// image_scan_grey
//   Frame-scan engine. After a start pulse it walks an RGB image BRAM in
//   raster order, converts each pixel to greyscale as (R + 2G + B) / 4 and
//   writes the result to a destination buffer. An internal valid/address
//   pipeline, READ_LATENCY deep, hides the BRAM read latency.
//
//   Optional build macro: IMAGE_SCAN_DECIMATE_EN
//     When defined, only pixels with even x and even y are written, to a
//     WIDTH/2 x HEIGHT/2 destination (2x2 decimation for the next pyramid
//     level). Reads are still issued for every pixel.
//
// Ports
//   clk_100mhz : system clock
//   sys_rst    : synchronous active-high reset
//   start      : one-cycle pulse, begins a frame scan when idle
//   hold       : while high, no new read address is issued
//   rd_addr    : source image BRAM address
//   rd_data    : source pixel {R,G,B}, valid READ_LATENCY cycles after rd_addr
//   wr_addr    : destination buffer address
//   wr_data    : greyscale pixel
//   wr_en      : destination write strobe
//   busy       : high while a frame is being processed
//   done       : one-cycle pulse after the final write
module image_scan_grey #(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 128,
  parameter int CH_BITS      = 4,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_BITS    = $clog2(WIDTH * HEIGHT)
) (
  input  logic                   clk_100mhz,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic                   hold,
  output logic [ADDR_BITS-1:0]   rd_addr,
  input  logic [3*CH_BITS-1:0]   rd_data,
  output logic [ADDR_BITS-1:0]   wr_addr,
  output logic [CH_BITS-1:0]     wr_data,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                state;
  logic                  issue;
  logic [READ_LATENCY-1:0] vld_p;
  logic [ADDR_BITS-1:0]  addr_p [READ_LATENCY];
  logic                  vld_out;
  logic [ADDR_BITS-1:0]  addr_out;
  logic                  wr_go;
  logic [ADDR_BITS-1:0]  wr_dst;

  // Exact (R + 2G + B) >> 2; CH_BITS+2 bits hold the worst case 4*(2^CH_BITS-1).
  function automatic logic [CH_BITS-1:0] grey(input logic [3*CH_BITS-1:0] px);
    logic [CH_BITS+1:0] sum;
    sum = {2'b00, px[3*CH_BITS-1:2*CH_BITS]}
        + {1'b0, px[2*CH_BITS-1:CH_BITS], 1'b0}
        + {2'b00, px[CH_BITS-1:0]};
    return sum[CH_BITS+1:2];
  endfunction

`ifdef IMAGE_SCAN_DECIMATE_EN
  localparam int                   X_BITS = $clog2(WIDTH);
  localparam logic [ADDR_BITS-1:0] X_MASK = ADDR_BITS'(WIDTH - 1);

  // (y/2)*(WIDTH/2) + x/2, with WIDTH a power of two this is pure bit surgery.
  function automatic logic [ADDR_BITS-1:0] decim_addr(input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS-1:0] x;
    logic [ADDR_BITS-1:0] y;
    x = a & X_MASK;
    y = a >> X_BITS;
    return ((y >> 1) << (X_BITS - 1)) | (x >> 1);
  endfunction

  assign wr_go  = vld_out && !addr_out[0] && !addr_out[X_BITS];
  assign wr_dst = decim_addr(addr_out);
`else
  assign wr_go  = vld_out;
  assign wr_dst = addr_out;
`endif

  assign issue    = (state == SCAN) && !hold;
  assign vld_out  = vld_p[READ_LATENCY-1];
  assign addr_out = addr_p[READ_LATENCY-1];

  // Control FSM: address generation and handshake
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SCAN;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (!hold) begin
            if (rd_addr == LAST_ADDR) state <= DRAIN;
            else                      rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Once the valid pipeline is empty, its last entry has been
          // registered into the write stage this very cycle.
          if (vld_p == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency stages: valid flags (reset) travel with their addresses
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      vld_p <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) vld_p[i] <= vld_p[i-1];
      vld_p[0] <= issue;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    for (int i = READ_LATENCY - 1; i > 0; i--) addr_p[i] <= addr_p[i-1];
    addr_p[0] <= rd_addr;
  end

  // Write stage: greyscale conversion registered onto the destination port
  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= wr_go;
      if (wr_go) begin
        wr_addr <= wr_dst;
        wr_data <= grey(rd_data);
      end
    end
  end

endmodule
